// File: rtl/popcount_stream_unit.sv
// Multi-cycle population counter with valid/ready handshakes on both sides.
// Counts ones (mode=0) or zeros (mode=1) in a DATA_WIDTH word, CHUNK_WIDTH bits per clock.
module popcount_stream_unit #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned CHUNK_WIDTH = 4,
   localparam int unsigned CW         = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  mode_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [CW-1:0]         dout_o,
   output logic                  busy_o
);

   localparam int unsigned NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

   if ((CHUNK_WIDTH == 0) || ((DATA_WIDTH % CHUNK_WIDTH) != 0)) begin : gen_bad_chunk
      $error("CHUNK_WIDTH must be nonzero and divide DATA_WIDTH");
   end
   if (DATA_WIDTH < 2) begin : gen_bad_width
      $error("DATA_WIDTH must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]         acc_q, acc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         dout_q, dout_d;
   logic [CW-1:0]         chunk_cnt;
   logic [CW-1:0]         acc_sum;

   // Popcount of the low chunk, each bit zero-extended to the count width.
   always_comb begin
      chunk_cnt = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         chunk_cnt = chunk_cnt + CW'(sh_q[i]);
      end
      acc_sum = acc_q + chunk_cnt;
   end

   // Next-state logic: capture at accept, consume one chunk per cycle, hold result until taken.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               // Inverting for zero-count lets the datapath always count ones.
               sh_d    = mode_i ? ~din_i : din_i;
               acc_d   = '0;
               idx_d   = '0;
               state_d = StCount;
            end
         end
         StCount: begin
            acc_d = acc_sum;
            sh_d  = sh_q >> CHUNK_WIDTH;
            idx_d = idx_q + IW'(1);
            if (idx_q == LastIdx) begin
               dout_d  = acc_sum;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous active-low reset; a reset discards any partial count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sh_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
      end
   end

   // Handshake and status outputs decode directly from the state register.
   always_comb begin
      in_ready_o  = (state_q == StIdle);
      out_valid_o = (state_q == StDone);
      busy_o      = (state_q != StIdle);
      dout_o      = dout_q;
   end

endmodule

// File: tb/tb_popcount_stream_unit.sv
// Directed bench for popcount_stream_unit with default parameters (16-bit word, 4-bit chunks).
module tb_popcount_stream_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [15:0] din_i = '0;
   logic        mode_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [4:0]  dout_o;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   popcount_stream_unit #(
      .DATA_WIDTH (16),
      .CHUNK_WIDTH(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .din_i      (din_i),
      .mode_i     (mode_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .dout_o     (dout_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one word, optionally scrambling inputs while busy, stall the consumer, check result.
   task automatic send(input logic [15:0] d, input logic m, input logic [4:0] exp,
                       input bit scramble, input int stall, input string tag);
      int lat;
      int guard;
      guard = 0;
      while (!in_ready_o && guard < 20) begin
         tick();
         guard++;
      end
      chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
      in_valid_i  = 1'b1;
      din_i       = d;
      mode_i      = m;
      out_ready_i = (stall == 0);
      tick();
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      in_valid_i = scramble;
      lat = 0;
      while (!out_valid_o && lat < 20) begin
         if (scramble) begin
            din_i  = 16'($urandom);
            mode_i = 1'($urandom_range(0, 1));
         end
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_dout"}, 32'(dout_o), 32'(exp));
      for (int i = 0; i < stall; i++) begin
         if (scramble) din_i = 16'($urandom);
         tick();
         chk({tag, "_stall_valid"}, 32'(out_valid_o), 32'd1);
         chk({tag, "_stall_dout"}, 32'(dout_o), 32'(exp));
         chk({tag, "_stall_ready"}, 32'(in_ready_o), 32'd0);
      end
      out_ready_i = 1'b1;
      tick();
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      chk({tag, "_drop_valid"}, 32'(out_valid_o), 32'd0);
      chk({tag, "_idle_ready"}, 32'(in_ready_o), 32'd1);
      chk({tag, "_dout_kept"}, 32'(dout_o), 32'(exp));
   endtask

   initial begin
      logic [15:0] rd;
      logic        rm;
      logic [4:0]  rexp;

      // Reset values while held in reset.
      #12;
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_dout", 32'(dout_o), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", 32'(in_ready_o), 32'd1);
      chk("rst_idle_busy", 32'(busy_o), 32'd0);

      // Idle with in_valid low stays idle.
      tick();
      chk("idle_hold", 32'(busy_o), 32'd0);

      // Basic counts.
      send(16'hFFFF, 1'b0, 5'd16, 1'b0, 0, "ones_all");
      send(16'h0000, 1'b1, 5'd16, 1'b0, 0, "zeros_all");
      send(16'hA5A5, 1'b0, 5'd8,  1'b0, 0, "a5a5");
      send(16'h0001, 1'b1, 5'd15, 1'b0, 0, "zeros_0001");
      send(16'h0000, 1'b0, 5'd0,  1'b0, 0, "ones_none");
      send(16'h8000, 1'b0, 5'd1,  1'b0, 0, "msb_only");

      // Backpressure with a competing word held on the input.
      send(16'h1234, 1'b0, 5'd5, 1'b1, 6, "bp");
      send(16'hF00F, 1'b1, 5'd8, 1'b0, 0, "after_bp");

      // Input changes while counting must not matter.
      send(16'h00F0, 1'b0, 5'd4, 1'b1, 0, "scramble");
      send(16'h7FFE, 1'b1, 5'd2, 1'b1, 2, "scramble_z");

      // Reset mid-count after two chunks.
      in_valid_i = 1'b1;
      din_i      = 16'hFFFF;
      mode_i     = 1'b0;
      tick();
      in_valid_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
      chk("mid_rst_dout", 32'(dout_o), 32'd0);
      chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
      #6;
      rst_n = 1'b1;
      tick();
      chk("post_rst_idle", 32'(busy_o), 32'd0);
      send(16'h0F0F, 1'b0, 5'd8, 1'b0, 0, "post_rst");

      // Random words with random stalls.
      for (int n = 0; n < 200; n++) begin
         rd   = 16'($urandom);
         rm   = 1'($urandom_range(0, 1));
         rexp = rm ? 5'(16 - $countones(rd)) : 5'($countones(rd));
         send(rd, rm, rexp, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time limit so the bench always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
